// File: rtl/fwd_hazard_unit_if.sv
// ID-stage request and forwarding/hazard response bundle for fwd_hazard_unit.
// The pipeline controller drives through 'master'; the hazard unit sits on 'slave'.
interface fwd_hazard_unit_if #(
    parameter int AW    = 5,
    parameter int CNT_W = 16
);
    logic             id_valid_i;
    logic [AW-1:0]    id_rs1_i;
    logic [AW-1:0]    id_rs2_i;
    logic             id_rs1_used_i;
    logic             id_rs2_used_i;
    logic [AW-1:0]    id_rd_i;
    logic             id_regwrite_i;
    logic             id_memread_i;
    logic             flush_i;
    logic             mem_ready_i;
    logic [1:0]       fwd_a_o;
    logic [1:0]       fwd_b_o;
    logic             byp_a_o;
    logic             byp_b_o;
    logic             stall_o;
    logic             freeze_o;
    logic [CNT_W-1:0] lu_cnt_o;
    logic [CNT_W-1:0] frz_cnt_o;

    modport master (
        output id_valid_i, id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i,
        output id_rd_i, id_regwrite_i, id_memread_i, flush_i, mem_ready_i,
        input  fwd_a_o, fwd_b_o, byp_a_o, byp_b_o, stall_o, freeze_o,
        input  lu_cnt_o, frz_cnt_o
    );

    modport slave (
        input  id_valid_i, id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i,
        input  id_rd_i, id_regwrite_i, id_memread_i, flush_i, mem_ready_i,
        output fwd_a_o, fwd_b_o, byp_a_o, byp_b_o, stall_o, freeze_o,
        output lu_cnt_o, frz_cnt_o
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding, load-use stall and memory-freeze control for a 5-stage pipeline.
// Shadow copies of IDEX/EXMEM/MEMWB track in-flight writers; outputs are combinational.
module fwd_hazard_unit #(
    parameter int AW        = 5,
    parameter int CNT_W     = 16,
    parameter int WB_BYPASS = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    fwd_hazard_unit_if.slave bus
);

    typedef struct packed {
        logic          v;
        logic [AW-1:0] rd;
        logic          rw;
        logic          mr;
    } stage_t;

    typedef struct packed {
        stage_t        base;
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic          u1;
        logic          u2;
    } idex_t;

    typedef enum logic {
        S_RUN,
        S_FREEZE
    } state_t;

    localparam logic BYP_EN = (WB_BYPASS != 0);

    idex_t            r_idex;
    stage_t           r_exmem;
    stage_t           r_memwb;
    state_t           r_state;
    state_t           w_nextState;
    logic             w_freeze;
    logic [CNT_W-1:0] r_luCnt;
    logic [CNT_W-1:0] r_frzCnt;

    logic             w_idexSrc;
    logic             w_exmemSrc;
    logic             w_memwbSrc;
    logic             w_hazard;
    logic             w_stall;
    logic             w_exHitA;
    logic             w_exHitB;
    logic             w_wbHitA;
    logic             w_wbHitB;
    logic [1:0]       w_fwdA;
    logic [1:0]       w_fwdB;

    function automatic logic isSource(input stage_t s);
        return s.v & s.rw & (s.rd != '0);
    endfunction

    assign w_idexSrc  = isSource(r_idex.base);
    assign w_exmemSrc = isSource(r_exmem);
    assign w_memwbSrc = isSource(r_memwb);

    // A load still in EX cannot supply its data yet, so its consumer waits one cycle.
    assign w_hazard = bus.id_valid_i & w_idexSrc & r_idex.base.mr &
                      ((bus.id_rs1_used_i & (bus.id_rs1_i == r_idex.base.rd)) |
                       (bus.id_rs2_used_i & (bus.id_rs2_i == r_idex.base.rd)));
    assign w_stall  = w_hazard & ~bus.flush_i & bus.mem_ready_i;

    assign w_exHitA = w_exmemSrc & r_idex.u1 & (r_exmem.rd == r_idex.rs1);
    assign w_exHitB = w_exmemSrc & r_idex.u2 & (r_exmem.rd == r_idex.rs2);
    assign w_wbHitA = w_memwbSrc & r_idex.u1 & (r_memwb.rd == r_idex.rs1);
    assign w_wbHitB = w_memwbSrc & r_idex.u2 & (r_memwb.rd == r_idex.rs2);

    // The younger EXMEM result wins over MEMWB; an EXMEM load is never a source.
    always_comb begin
        w_fwdA = 2'b00;
        w_fwdB = 2'b00;
        if (r_idex.base.v) begin
            if (w_exHitA && !r_exmem.mr) begin
                w_fwdA = 2'b10;
            end else if (w_wbHitA) begin
                w_fwdA = 2'b01;
            end
            if (w_exHitB && !r_exmem.mr) begin
                w_fwdB = 2'b10;
            end else if (w_wbHitB) begin
                w_fwdB = 2'b01;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = S_RUN;
        w_freeze    = 1'b0;
        if (!bus.mem_ready_i) begin
            w_nextState = S_FREEZE;
            w_freeze    = 1'b1;
        end
    end

    // Stages hold while memory is busy; a stall or flush injects a bubble into IDEX.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_idex  <= '0;
            r_exmem <= '0;
            r_memwb <= '0;
        end else if (bus.mem_ready_i) begin
            r_memwb <= r_exmem;
            r_exmem <= r_idex.base;
            if (bus.flush_i || w_stall) begin
                r_idex <= '0;
            end else begin
                r_idex <= '{
                    base: '{
                        v:  bus.id_valid_i,
                        rd: bus.id_rd_i,
                        rw: bus.id_regwrite_i,
                        mr: bus.id_memread_i
                    },
                    rs1: bus.id_rs1_i,
                    rs2: bus.id_rs2_i,
                    u1:  bus.id_rs1_used_i,
                    u2:  bus.id_rs2_used_i
                };
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_luCnt  <= '0;
            r_frzCnt <= '0;
        end else begin
            if (w_stall && (r_luCnt != '1)) begin
                r_luCnt <= r_luCnt + 1'b1;
            end
            if (w_freeze && (r_frzCnt != '1)) begin
                r_frzCnt <= r_frzCnt + 1'b1;
            end
        end
    end

    assign bus.fwd_a_o   = w_fwdA;
    assign bus.fwd_b_o   = w_fwdB;
    assign bus.byp_a_o   = BYP_EN & w_memwbSrc & bus.id_rs1_used_i & (r_memwb.rd == bus.id_rs1_i);
    assign bus.byp_b_o   = BYP_EN & w_memwbSrc & bus.id_rs2_used_i & (r_memwb.rd == bus.id_rs2_i);
    assign bus.stall_o   = w_stall;
    assign bus.freeze_o  = w_freeze;
    assign bus.lu_cnt_o  = r_luCnt;
    assign bus.frz_cnt_o = r_frzCnt;

    // The stall logic must keep a load in EXMEM away from any matching consumer.
    assert property (@(posedge clk_i) disable iff (rst_i)
        !(r_idex.base.v && r_exmem.mr && (w_exHitA || w_exHitB)));

    assert property (@(posedge clk_i) disable iff (rst_i)
        (r_state == S_FREEZE) |-> ($stable(r_idex) && $stable(r_exmem) && $stable(r_memwb)));

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed pipeline scenarios with literal pins, then random
// traffic, all compared every cycle against an instruction-list model of the pipeline.
module tb_fwd_hazard_unit;

    localparam int AW      = 5;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;

    typedef struct {
        bit v;
        int rd;
        bit rw;
        bit mr;
        int rs1;
        int rs2;
        bit u1;
        bit u2;
    } instr_t;

    logic clk;
    logic rst;
    int   checkCount;
    int   passCount;

    instr_t pipe[3];
    instr_t cur;
    bit     curFlush;
    bit     curReady;
    bit     curRst;
    int     mLu;
    int     mFrz;

    fwd_hazard_unit_if #(.AW(AW), .CNT_W(CNT_W)) bus ();

    fwd_hazard_unit #(
        .AW(AW),
        .CNT_W(CNT_W),
        .WB_BYPASS(1)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic instr_t mk(bit v, int rd, bit rw, bit mr, int rs1, int rs2, bit u1, bit u2);
        instr_t e;
        e.v = v; e.rd = rd; e.rw = rw; e.mr = mr;
        e.rs1 = rs1; e.rs2 = rs2; e.u1 = u1; e.u2 = u2;
        return e;
    endfunction

    function automatic bit writes(instr_t e);
        return e.v && e.rw && (e.rd != 0);
    endfunction

    // Index 0 is the instruction in EX, 1 in MEM, 2 in WB; search youngest first.
    function automatic logic [1:0] expFwd(int src, bit used);
        if (!pipe[0].v || !used) return 2'b00;
        for (int k = 1; k <= 2; k++) begin
            if (writes(pipe[k]) && pipe[k].rd == src && !(k == 1 && pipe[k].mr))
                return (k == 1) ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    function automatic bit expStall();
        bit hz;
        hz = cur.v && writes(pipe[0]) && pipe[0].mr &&
             ((cur.u1 && cur.rs1 == pipe[0].rd) || (cur.u2 && cur.rs2 == pipe[0].rd));
        return hz && !curFlush && curReady;
    endfunction

    function automatic bit expByp(int src, bit used);
        return used && writes(pipe[2]) && pipe[2].rd == src;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        else
            passCount++;
    endtask

    task automatic applyStimulus(input instr_t ins, input bit flush, input bit ready, input bit rstIn);
        cur      = ins;
        curFlush = flush;
        curReady = ready;
        curRst   = rstIn;
        rst               = rstIn;
        bus.id_valid_i    = ins.v;
        bus.id_rd_i       = AW'(ins.rd);
        bus.id_regwrite_i = ins.rw;
        bus.id_memread_i  = ins.mr;
        bus.id_rs1_i      = AW'(ins.rs1);
        bus.id_rs2_i      = AW'(ins.rs2);
        bus.id_rs1_used_i = ins.u1;
        bus.id_rs2_used_i = ins.u2;
        bus.flush_i       = flush;
        bus.mem_ready_i   = ready;
        #1;
    endtask

    task automatic modelCompare();
        if (curRst) return;
        checkOutput("fwd_a", bus.fwd_a_o, expFwd(pipe[0].rs1, pipe[0].u1));
        checkOutput("fwd_b", bus.fwd_b_o, expFwd(pipe[0].rs2, pipe[0].u2));
        checkOutput("byp_a", bus.byp_a_o, expByp(cur.rs1, cur.u1));
        checkOutput("byp_b", bus.byp_b_o, expByp(cur.rs2, cur.u2));
        checkOutput("stall", bus.stall_o, expStall());
        checkOutput("freeze", bus.freeze_o, !curReady);
        checkOutput("lu_cnt", bus.lu_cnt_o, mLu);
        checkOutput("frz_cnt", bus.frz_cnt_o, mFrz);
    endtask

    task automatic modelAdvance();
        bit st;
        if (curRst) begin
            for (int k = 0; k < 3; k++) pipe[k] = mk(0, 0, 0, 0, 0, 0, 0, 0);
            mLu  = 0;
            mFrz = 0;
        end else if (!curReady) begin
            mFrz = (mFrz < CNT_MAX) ? mFrz + 1 : CNT_MAX;
        end else begin
            st = expStall();
            if (st) mLu = (mLu < CNT_MAX) ? mLu + 1 : CNT_MAX;
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = (curFlush || st) ? mk(0, 0, 0, 0, 0, 0, 0, 0) : cur;
        end
    endtask

    task automatic clockCycle();
        modelAdvance();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step(input instr_t ins, input bit flush, input bit ready, input bit rstIn);
        applyStimulus(ins, flush, ready, rstIn);
        modelCompare();
    endtask

    initial begin
        instr_t nop;
        instr_t r;
        checkCount = 0;
        passCount  = 0;
        nop = mk(0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) pipe[k] = nop;
        mLu = 0;
        mFrz = 0;
        rst = 1'b1;
        applyStimulus(nop, 0, 1, 1);
        @(negedge clk);
        step(nop, 0, 1, 1); clockCycle();
        step(nop, 0, 1, 1); clockCycle();

        // First cycle out of reset: everything quiet.
        step(nop, 0, 1, 0);
        checkOutput("rst_fwd_a", bus.fwd_a_o, 0);
        checkOutput("rst_stall", bus.stall_o, 0);
        checkOutput("rst_freeze", bus.freeze_o, 0);
        checkOutput("rst_lu_cnt", bus.lu_cnt_o, 0);
        clockCycle();

        // ALU x5 followed by two consumers of x5.
        step(mk(1, 5, 1, 0, 0, 0, 0, 0), 0, 1, 0); clockCycle();
        step(mk(1, 6, 1, 0, 5, 0, 1, 0), 0, 1, 0);
        checkOutput("alu_stall0", bus.stall_o, 0);
        clockCycle();
        step(mk(1, 11, 1, 0, 5, 0, 1, 0), 0, 1, 0);
        checkOutput("alu_fwd_a_exmem", bus.fwd_a_o, 2'b10);
        clockCycle();
        step(mk(1, 0, 0, 0, 5, 0, 1, 0), 0, 1, 0);
        checkOutput("alu_fwd_a_memwb", bus.fwd_a_o, 2'b01);
        checkOutput("alu_byp_a", bus.byp_a_o, 1);
        clockCycle();

        // Load x7 then immediate consumer on rs2.
        step(mk(1, 7, 1, 1, 0, 0, 0, 0), 0, 1, 0); clockCycle();
        step(mk(1, 8, 1, 0, 0, 7, 0, 1), 0, 1, 0);
        checkOutput("lu_stall1", bus.stall_o, 1);
        clockCycle();
        step(mk(1, 8, 1, 0, 0, 7, 0, 1), 0, 1, 0);
        checkOutput("lu_stall_once", bus.stall_o, 0);
        checkOutput("lu_cnt1", bus.lu_cnt_o, 1);
        checkOutput("lu_fwd_b_bubble", bus.fwd_b_o, 2'b00);
        clockCycle();
        step(nop, 0, 1, 0);
        checkOutput("lu_fwd_b_memwb", bus.fwd_b_o, 2'b01);
        clockCycle();

        // Writers of x0 never forward, stall or bypass.
        step(mk(1, 0, 1, 0, 0, 0, 0, 0), 0, 1, 0); clockCycle();
        step(mk(1, 0, 1, 1, 0, 0, 0, 0), 0, 1, 0); clockCycle();
        step(mk(1, 12, 1, 0, 0, 0, 1, 1), 0, 1, 0);
        checkOutput("x0_stall", bus.stall_o, 0);
        clockCycle();
        step(mk(1, 0, 0, 0, 0, 0, 1, 1), 0, 1, 0);
        checkOutput("x0_fwd_a", bus.fwd_a_o, 0);
        checkOutput("x0_fwd_b", bus.fwd_b_o, 0);
        checkOutput("x0_byp_a", bus.byp_a_o, 0);
        checkOutput("x0_byp_b", bus.byp_b_o, 0);
        clockCycle();

        // Two writers of x3: the younger one wins.
        step(mk(1, 3, 1, 0, 0, 0, 0, 0), 0, 1, 0); clockCycle();
        step(mk(1, 3, 1, 0, 0, 0, 0, 0), 0, 1, 0); clockCycle();
        step(mk(1, 13, 1, 0, 3, 0, 1, 0), 0, 1, 0); clockCycle();
        step(nop, 0, 1, 0);
        checkOutput("prio_fwd_a", bus.fwd_a_o, 2'b10);
        clockCycle();

        // Load-use hazard squashed by flush.
        step(mk(1, 9, 1, 1, 0, 0, 0, 0), 0, 1, 0); clockCycle();
        step(mk(1, 14, 1, 0, 9, 0, 1, 0), 1, 1, 0);
        checkOutput("flush_stall0", bus.stall_o, 0);
        clockCycle();
        step(nop, 0, 1, 0);
        checkOutput("flush_bubble_fwd", bus.fwd_a_o, 0);
        checkOutput("flush_lu_cnt", bus.lu_cnt_o, 1);
        clockCycle();

        // Load-use hazard held across a three-cycle memory wait.
        step(mk(1, 10, 1, 1, 0, 0, 0, 0), 0, 1, 0); clockCycle();
        for (int i = 0; i < 3; i++) begin
            step(mk(1, 15, 1, 0, 10, 0, 1, 0), 0, 0, 0);
            checkOutput("frz_freeze", bus.freeze_o, 1);
            checkOutput("frz_stall0", bus.stall_o, 0);
            clockCycle();
        end
        step(mk(1, 15, 1, 0, 10, 0, 1, 0), 0, 1, 0);
        checkOutput("frz_cnt3", bus.frz_cnt_o, 3);
        checkOutput("frz_then_stall", bus.stall_o, 1);
        clockCycle();
        step(mk(1, 15, 1, 0, 10, 0, 1, 0), 0, 1, 0);
        checkOutput("frz_lu_cnt2", bus.lu_cnt_o, 2);
        clockCycle();
        step(nop, 0, 1, 0);
        checkOutput("frz_fwd_a_memwb", bus.fwd_a_o, 2'b01);
        clockCycle();

        // Freeze counter saturates, then reset mid-freeze discards x5 in flight.
        step(mk(1, 5, 1, 0, 0, 0, 0, 0), 0, 1, 0); clockCycle();
        for (int i = 0; i < 20; i++) begin
            step(nop, 0, 0, 0); clockCycle();
        end
        step(nop, 0, 0, 0);
        checkOutput("sat_frz_cnt", bus.frz_cnt_o, CNT_MAX);
        clockCycle();
        step(nop, 0, 0, 1); clockCycle();
        step(nop, 0, 1, 0);
        checkOutput("post_rst_frz_cnt", bus.frz_cnt_o, 0);
        checkOutput("post_rst_lu_cnt", bus.lu_cnt_o, 0);
        checkOutput("post_rst_freeze", bus.freeze_o, 0);
        checkOutput("post_rst_fwd_a", bus.fwd_a_o, 0);
        clockCycle();
        step(mk(1, 0, 0, 0, 5, 0, 1, 0), 0, 1, 0);
        checkOutput("post_rst_byp_a", bus.byp_a_o, 0);
        clockCycle();

        // Random traffic over a small register set to provoke frequent matches.
        for (int n = 0; n < 3000; n++) begin
            r = mk(($urandom % 4) != 0, $urandom % 4, $urandom % 2, ($urandom % 10) < 3,
                   $urandom % 4, $urandom % 4, $urandom % 2, $urandom % 2);
            step(r, ($urandom % 10) == 0, ($urandom % 10) < 8, ($urandom % 100) == 0);
            clockCycle();
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- AW, 5, register address width.
- CNT_W, 16, width of each performance counter.
- WB_BYPASS, 1, enables ID-stage write-back bypass outputs (0 ties them low).
REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk_i, in, 1, the single clock; all state updates on its rising edge.
- rst_i, in, 1, reset; synchronous, active-high.
- id_valid_i, in, 1, the ID-stage instruction is valid.
- id_rs1_i, in, AW, ID-stage source address 1.
- id_rs2_i, in, AW, ID-stage source address 2.
- id_rs1_used_i, in, 1, the ID-stage instruction reads rs1.
- id_rs2_used_i, in, 1, the ID-stage instruction reads rs2.
- id_rd_i, in, AW, ID-stage destination address.
- id_regwrite_i, in, 1, the ID-stage instruction writes rd.
- id_memread_i, in, 1, the ID-stage instruction is a load.
- flush_i, in, 1, squash the ID-stage instruction (taken branch).
- mem_ready_i, in, 1, data memory completes this cycle; 0 freezes the pipeline.
- fwd_a_o, out, 2, EX operand A select: 00 register file, 10 EX/MEM, 01 MEM/WB.
- fwd_b_o, out, 2, EX operand B select, same encoding as fwd_a_o.
- byp_a_o, out, 1, MEM/WB writes id_rs1_i this cycle (register-file write-through).
- byp_b_o, out, 1, MEM/WB writes id_rs2_i this cycle.
- stall_o, out, 1, hold PC and IF/ID (load-use hazard).
- freeze_o, out, 1, hold all pipeline registers (memory wait).
- lu_cnt_o, out, CNT_W, load-use stall cycles.
- frz_cnt_o, out, CNT_W, freeze cycles.

Function
REQ-003 The block SHALL keep three shadow stages, IDEX, EXMEM and MEMWB; each holds {v, rd, rw, mr}, and IDEX additionally holds {rs1, rs2, u1, u2}.
REQ-004 An entry SHALL be a write source only when v=1, rw=1 and rd!=0.
REQ-005 The FSM SHALL have two states, RUN and FREEZE; next state is FREEZE when mem_ready_i=0 and RUN otherwise; freeze_o=1 exactly when mem_ready_i=0.
REQ-006 In a freeze cycle, all stages, both counters' non-freeze paths and the state of every stage SHALL hold; stall_o=0; flush_i is ignored (the caller keeps flush_i asserted until the freeze ends).
REQ-007 Load-use hazard: hz = id_valid_i & IDEX write source & IDEX.mr & ((id_rs1_used_i & id_rs1_i==IDEX.rd) | (id_rs2_used_i & id_rs2_i==IDEX.rd)).
REQ-008 stall_o SHALL equal hz & ~flush_i & mem_ready_i.
REQ-009 Advance (mem_ready_i=1): MEMWB<=EXMEM and EXMEM<=IDEX.
REQ-010 On advance, IDEX SHALL receive a bubble (v=0) when flush_i=1 or stall_o=1, and otherwise the ID inputs with v=id_valid_i.
REQ-011 fwd_a_o SHALL be 10 if EXMEM is a write source & ~EXMEM.mr & IDEX.u1 & EXMEM.rd==IDEX.rs1; else 01 if MEMWB is a write source & IDEX.u1 & MEMWB.rd==IDEX.rs1; else 00. fwd_b_o is identical using u2/rs2.
REQ-012 When IDEX.v=0, fwd_a_o and fwd_b_o SHALL be 00.
REQ-013 EXMEM SHALL take priority over MEMWB when both match.
REQ-014 An EXMEM load SHALL never be selected as a forwarding source; that case is a protocol error reported by an assertion.
REQ-015 byp_a_o SHALL be WB_BYPASS & MEMWB write source & id_rs1_used_i & MEMWB.rd==id_rs1_i; byp_b_o is identical using rs2.
REQ-016 All outputs except the counters SHALL be combinational from the current state and inputs; load-use adds exactly one bubble cycle and forwarding adds zero latency.
REQ-017 lu_cnt_o SHALL increment on each stall_o=1 cycle, and frz_cnt_o on each freeze_o=1 cycle; both saturate at all-ones and never wrap.

Reset
REQ-018 While rst_i=1 at a clock edge, all stage v bits and both counters SHALL clear and the state SHALL become RUN; rst_i overrides mem_ready_i and flush_i.
REQ-019 In the first cycle after reset, with mem_ready_i=1 and no ID inputs asserted, every output SHALL be 0.
REQ-020 Reset asserted mid-stall or mid-freeze SHALL discard all in-flight entries; no stale forwarding is permitted after reset.

Verification
REQ-021 ALU x5 then consumer reading x5 (rs1) on the next instruction -> fwd_a_o=10 while the consumer is in EX; one instruction later -> 01; stall_o=0 throughout.
REQ-022 Load x7 then consumer reading x7 (rs2) immediately -> stall_o=1 for exactly one cycle with lu_cnt_o=1; then fwd_b_o=01 and fwd_b_o never equals 10.
REQ-023 Writes to x0 in any stage -> fwd_a_o=fwd_b_o=00, stall_o=0 and byp_a_o=byp_b_o=0.
REQ-024 Same rd=x3 in EXMEM and MEMWB with a consumer reading x3 -> fwd_a_o=10.
REQ-025 Load-use hazard with flush_i=1 -> stall_o=0 and IDEX receives a bubble; a hazard with mem_ready_i=0 for 3 cycles -> freeze_o=1, all stages hold, frz_cnt_o=3, then the one-cycle stall occurs.
REQ-026 CNT_W=4 with 20 freeze cycles -> frz_cnt_o=15; rst_i pulsed mid-freeze -> all outputs 0 on the next cycle.
